// File: rtl/lapido_pkg.sv
// lapido_pkg: definitions shared between the Lapido control unit and the
// instruction encoder.
//   - opType     : 6-bit symbolic operation enum (30 legal values)
//   - CLASS_*    : 3-bit instruction class codes, word bits [31:29]
//   - FN_*       : 5-bit function codes, word bits [28:24] (ALUOp encoding)
//   - *_LSB      : field bit positions inside the 32-bit word
//   - packFields : assembles a word from class, function and operand fields
package lapido_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC, OP_SUB, OP_DECA, OP_LSL, OP_ASR,
    OP_ZEROS, OP_AND, OP_ANDNOTA, OP_PASSB, OP_ANDNOTB, OP_PASSA, OP_XOR, OP_OR,
    OP_NAND, OP_XNOR, OP_PASSNOTA, OP_ORNOTA, OP_PASSNOTB, OP_ORNOTB, OP_NOR, OP_ONES,
    OP_LOAD, OP_STORE, OP_LOADLIT, OP_NOP, OP_BEQ, OP_BNE
  } opType;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PAD, S_DONE
  } stateType;

  localparam logic [2:0] CLASS_NOP    = 3'b000;
  localparam logic [2:0] CLASS_ALU    = 3'b001;
  localparam logic [2:0] CLASS_CONST  = 3'b010;
  localparam logic [2:0] CLASS_MEM    = 3'b100;
  localparam logic [2:0] CLASS_BRANCH = 3'b101;

  localparam logic [4:0] FN_ADD        = 5'b00000;
  localparam logic [4:0] FN_ADDINC     = 5'b00001;
  localparam logic [4:0] FN_INCA       = 5'b00011;
  localparam logic [4:0] FN_SUBDEC     = 5'b00100;
  localparam logic [4:0] FN_SUB        = 5'b00101;
  localparam logic [4:0] FN_DECA       = 5'b00110;
  localparam logic [4:0] FN_LSL        = 5'b01000;
  localparam logic [4:0] FN_ASR        = 5'b01001;
  // The sixteen bitwise functions occupy 10000..11111 in enum order.
  localparam logic [4:0] FN_LOGIC_BASE = 5'b10000;
  localparam logic [4:0] FN_LOAD       = 5'b00000;
  localparam logic [4:0] FN_STORE      = 5'b00001;
  localparam logic [4:0] FN_LOADLIT    = 5'b00010;
  localparam logic [4:0] FN_BEQ        = 5'b00100;
  localparam logic [4:0] FN_BNE        = 5'b01000;

  localparam int CLASS_LSB = 29;
  localparam int FN_LSB    = 24;
  localparam int RD_LSB    = 20;
  localparam int RA_LSB    = 16;
  localparam int RB_LSB    = 12;
  localparam int IMM_LSB   = 0;

  localparam logic [31:0] NOP_WORD = {CLASS_NOP, 29'b0};

  // The immediate overlays the rb field, so only one of them is placed.
  function automatic logic [31:0] packFields(
    input logic [2:0]  cls,
    input logic [4:0]  fn,
    input logic [3:0]  rd,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [15:0] imm,
    input logic        useImm
  );
    logic [31:0] word;
    word = (32'(cls) << CLASS_LSB) | (32'(fn) << FN_LSB)
         | (32'(rd) << RD_LSB) | (32'(ra) << RA_LSB);
    word = word | (useImm ? (32'(imm) << IMM_LSB) : (32'(rb) << RB_LSB));
    return word;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational operation -> instruction word packer.
// Ports:
//   op        in  6   operation enum (opType values; others are illegal)
//   rd/ra/rb  in  4   register fields
//   imm       in  16  immediate for memory, constant and branch operations
//   legal     out 1   op is a defined enum value
//   word      out 32  encoded word (NOP_WORD when illegal)
module instr_pack
  import lapido_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [3:0]  rd,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [15:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    legal = 1'b1;
    word  = NOP_WORD;
    case (op)
      OP_ADD:     word = packFields(CLASS_ALU, FN_ADD,    rd, ra, rb, imm, 1'b0);
      OP_ADDINC:  word = packFields(CLASS_ALU, FN_ADDINC, rd, ra, rb, imm, 1'b0);
      OP_INCA:    word = packFields(CLASS_ALU, FN_INCA,   rd, ra, rb, imm, 1'b0);
      OP_SUBDEC:  word = packFields(CLASS_ALU, FN_SUBDEC, rd, ra, rb, imm, 1'b0);
      OP_SUB:     word = packFields(CLASS_ALU, FN_SUB,    rd, ra, rb, imm, 1'b0);
      OP_DECA:    word = packFields(CLASS_ALU, FN_DECA,   rd, ra, rb, imm, 1'b0);
      OP_LSL:     word = packFields(CLASS_ALU, FN_LSL,    rd, ra, rb, imm, 1'b0);
      OP_ASR:     word = packFields(CLASS_ALU, FN_ASR,    rd, ra, rb, imm, 1'b0);
      OP_LOAD:    word = packFields(CLASS_MEM, FN_LOAD,   rd, ra, rb, imm, 1'b1);
      OP_STORE:   word = packFields(CLASS_MEM, FN_STORE,  rd, ra, rb, imm, 1'b1);
      OP_LOADLIT: word = packFields(CLASS_CONST, FN_LOADLIT, rd, ra, rb, imm, 1'b1);
      OP_NOP:     word = NOP_WORD;
      OP_BEQ:     word = packFields(CLASS_BRANCH, FN_BEQ, rd, ra, rb, imm, 1'b1);
      OP_BNE:     word = packFields(CLASS_BRANCH, FN_BNE, rd, ra, rb, imm, 1'b1);
      default: begin
        // Bitwise ops are contiguous in the enum, so their function code is
        // the base plus the offset from OP_ZEROS.
        if (op >= OP_ZEROS && op <= OP_ONES)
          word = packFields(CLASS_ALU, FN_LOGIC_BASE + 5'(op - OP_ZEROS),
                            rd, ra, rb, imm, 1'b0);
        else
          legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic operations over valid/ready, packs them
// into 32-bit Lapido words and writes them sequentially to instruction memory.
// Optional feature macro: INSTR_ENCODER_BRANCH_PAD_EN -- when defined, every
// written beq/bne is followed by a NOP in the next slot (PAD state).
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 clear address/count/err/done and enter RUN
//   in_valid/in_ready     beat handshake
//   in_op, in_rd, in_ra, in_rb, in_imm, in_last   beat payload
//   imem_we/addr/wdata    registered instruction-memory write port
//   count                 words written since start
//   done                  program complete, held until start/reset
//   err                   sticky: illegal op or address wrap
module instr_encoder
  import lapido_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  stateType          state, nextState;
  logic [ADDR_W-1:0] writeAddr;
  logic              packLegal;
  logic [31:0]       packWord;
  logic              accept;

  assign accept = in_valid && in_ready;

`ifdef INSTR_ENCODER_BRANCH_PAD_EN
  logic isBranch;
  logic padLast;   // the branch that triggered PAD was the final beat
  assign isBranch = (in_op == OP_BEQ) || (in_op == OP_BNE);
`endif

  instr_pack packer (
    .op    (in_op),
    .rd    (in_rd),
    .ra    (in_ra),
    .rb    (in_rb),
    .imm   (in_imm),
    .legal (packLegal),
    .word  (packWord)
  );

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // Next-state logic; start overrides everything, including a pending pad.
  always_comb begin
    nextState = state;
    if (start) begin
      nextState = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (accept) begin
            if (in_last) nextState = S_DONE;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
            if (packLegal && isBranch) nextState = S_PAD;
`endif
          end
        end
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
        S_PAD:   nextState = padLast ? S_DONE : S_RUN;
`endif
        S_IDLE:  nextState = S_IDLE;
        S_DONE:  nextState = S_DONE;
        default: nextState = S_IDLE;
      endcase
    end
  end

  // Output logic: a beat presented alongside start is never accepted.
  always_comb begin
    in_ready = (state == S_RUN) && !start;
  end

  // Write port, address counter and status. Everything is registered, so a
  // beat accepted in cycle N appears on the write port in cycle N+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      writeAddr  <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
      padLast    <= 1'b0;
`endif
    end else if (start) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      writeAddr  <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
      padLast    <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      // done trails the DONE state by a cycle so it rises after the last write.
      done    <= (state == S_DONE);
      // The write now on the port hit the top address: flag the wrap.
      if (imem_we && imem_addr == {ADDR_W{1'b1}}) err <= 1'b1;
      if (accept) begin
        if (packLegal) begin
          imem_we    <= 1'b1;
          imem_addr  <= writeAddr;
          imem_wdata <= packWord;
          writeAddr  <= writeAddr + 1'b1;
          count      <= count + 1'b1;
        end else begin
          err <= 1'b1;
        end
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
        padLast <= in_last;
`endif
      end
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
      if (state == S_PAD) begin
        imem_we    <= 1'b1;
        imem_addr  <= writeAddr;
        imem_wdata <= NOP_WORD;
        writeAddr  <= writeAddr + 1'b1;
        count      <= count + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder. A second instance with ADDR_W=2
// shares the stimulus and is used for the address-wrap checks.
module tb_instr_encoder;
  import lapido_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [5:0]  in_op;
  logic [3:0]  in_rd, in_ra, in_rb;
  logic [15:0] in_imm;

  logic        readyA, weA, doneA, errA;
  logic [7:0]  addrA;
  logic [31:0] dataA;
  logic [8:0]  countA;

  logic        readyB, weB, doneB, errB;
  logic [1:0]  addrB;
  logic [31:0] dataB;
  logic [2:0]  countB;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  instr_encoder #(.ADDR_W(8)) dutA (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(readyA), .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra),
    .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last), .imem_we(weA),
    .imem_addr(addrA), .imem_wdata(dataA), .count(countA), .done(doneA),
    .err(errA)
  );

  instr_encoder #(.ADDR_W(2)) dutB (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(readyB), .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra),
    .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last), .imem_we(weB),
    .imem_addr(addrB), .imem_wdata(dataB), .count(countB), .done(doneB),
    .err(errB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [15:0] imm, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_ra    = ra;
    in_rb    = rb;
    in_imm   = imm;
    in_last  = last;
    #1;
  endtask

  task automatic noBeat();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0; in_imm = '0;
    tick(); tick();

    // Reset values.
    check("rst_ready", 32'(readyA), 32'd0);
    check("rst_we",    32'(weA),    32'd0);
    check("rst_addr",  32'(addrA),  32'd0);
    check("rst_data",  dataA,       32'd0);
    check("rst_count", 32'(countA), 32'd0);
    check("rst_done",  32'(doneA),  32'd0);
    check("rst_err",   32'(errA),   32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(readyA), 32'd0);

    // Single add.
    pulseStart();
    check("run_ready", 32'(readyA), 32'd1);
    beat(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick(); noBeat();
    check("add_we",    32'(weA),    32'd1);
    check("add_addr",  32'(addrA),  32'd0);
    check("add_data",  dataA,       32'h20123000);
    check("add_count", 32'(countA), 32'd1);
    tick();
    check("add_we_off", 32'(weA), 32'd0);

    // Back-to-back sub, loadlit, store(last).
    pulseStart();
    beat(OP_SUB, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("sub_addr", 32'(addrA), 32'd0);
    check("sub_data", dataA,      32'h25123000);
    beat(OP_LOADLIT, 4'd6, 4'd7, 4'd0, 16'h00AB, 1'b0);
    check("b2b_ready", 32'(readyA), 32'd1);
    tick();
    check("ll_we",   32'(weA),   32'd1);
    check("ll_addr", 32'(addrA), 32'd1);
    check("ll_data", dataA,      32'h426700AB);
    beat(OP_STORE, 4'd4, 4'd5, 4'd0, 16'h0010, 1'b1);
    tick(); noBeat();
    check("st_addr",      32'(addrA),  32'd2);
    check("st_data",      dataA,       32'h81450010);
    check("st_done_early", 32'(doneA), 32'd0);
    check("st_ready_off", 32'(readyA), 32'd0);
    tick();
    check("st_done",  32'(doneA),  32'd1);
    check("st_we",    32'(weA),    32'd0);
    check("st_count", 32'(countA), 32'd3);

    // Illegal op between two legal beats.
    pulseStart();
    check("start_clr_done", 32'(doneA), 32'd0);
    beat(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("il_first_addr", 32'(addrA), 32'd0);
    beat(6'd63, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0);
    tick();
    check("il_no_write", 32'(weA),  32'd0);
    check("il_err",      32'(errA), 32'd1);
    beat(OP_INCA, 4'd8, 4'd9, 4'd0, 16'h0, 1'b1);
    tick(); noBeat();
    check("il_next_we",   32'(weA),    32'd1);
    check("il_next_addr", 32'(addrA),  32'd1);
    check("il_next_data", dataA,       32'h23890000);
    check("il_count",     32'(countA), 32'd2);
    tick();
    check("il_done",       32'(doneA), 32'd1);
    check("il_err_sticky", 32'(errA),  32'd1);

    // Illegal op carrying in_last still finishes the program.
    pulseStart();
    check("start_clr_err", 32'(errA), 32'd0);
    beat(6'd40, 4'd0, 4'd0, 4'd0, 16'h0, 1'b1);
    tick(); noBeat();
    check("illast_we",    32'(weA),    32'd0);
    check("illast_ready", 32'(readyA), 32'd0);
    tick();
    check("illast_done", 32'(doneA), 32'd1);

    // Five beats: ADDR_W=2 instance wraps 3 -> 0 and flags err.
    pulseStart();
    beat(OP_ZEROS, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("w0_data",  dataA,       32'h30123000);
    check("w0_addrB", 32'(addrB),  32'd0);
    beat(OP_XOR, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("w1_data",  dataA,       32'h36123000);
    check("w1_addrB", 32'(addrB),  32'd1);
    beat(OP_NOR, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("w2_data",  dataA,       32'h3E123000);
    check("w2_addrB", 32'(addrB),  32'd2);
    beat(OP_LSL, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    check("w3_data",  dataA,       32'h28123000);
    check("w3_addrB", 32'(addrB),  32'd3);
    check("w3_errB",  32'(errB),   32'd0);
    beat(OP_ASR, 4'd1, 4'd2, 4'd3, 16'h0, 1'b1);
    tick(); noBeat();
    check("w4_data",   dataA,       32'h29123000);
    check("w4_addrA",  32'(addrA),  32'd4);
    check("w4_weB",    32'(weB),    32'd1);
    check("w4_addrB",  32'(addrB),  32'd0);
    check("w4_errB",   32'(errB),   32'd1);
    check("w4_errA",   32'(errA),   32'd0);
    check("w4_countB", 32'(countB), 32'd5);
    tick();
    check("w_doneA", 32'(doneA), 32'd1);

    // Branch, optionally followed by a pad NOP.
    pulseStart();
    beat(OP_BEQ, 4'd0, 4'd0, 4'd0, 16'h0004, 1'b0);
    tick();
    check("beq_addr", 32'(addrA), 32'd0);
    check("beq_data", dataA,      32'hA4000004);
    beat(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b1);
`ifdef INSTR_ENCODER_BRANCH_PAD_EN
    check("pad_ready", 32'(readyA), 32'd0);
    tick();
    check("pad_we",    32'(weA),    32'd1);
    check("pad_addr",  32'(addrA),  32'd1);
    check("pad_data",  dataA,       32'h00000000);
    check("pad_count", 32'(countA), 32'd2);
    check("pad_ready_back", 32'(readyA), 32'd1);
    tick(); noBeat();
    check("pad_add_addr",  32'(addrA),  32'd2);
    check("pad_add_data",  dataA,       32'h20123000);
    check("pad_add_count", 32'(countA), 32'd3);
`else
    check("nopad_ready", 32'(readyA), 32'd1);
    tick(); noBeat();
    check("nopad_add_addr",  32'(addrA),  32'd1);
    check("nopad_add_data",  dataA,       32'h20123000);
    check("nopad_add_count", 32'(countA), 32'd2);
`endif
    tick();
    check("br_done", 32'(doneA), 32'd1);

    // bne encoding.
    pulseStart();
    beat(OP_BNE, 4'd2, 4'd3, 4'd0, 16'h1234, 1'b0);
    tick(); noBeat();
    check("bne_data", dataA, 32'hA8231234);
    tick();

    // start mid-stream with in_valid high.
    pulseStart();
    beat(6'd63, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0);
    tick();
    beat(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    start = 1'b1;
    beat(OP_SUB, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    check("ms_ready_start", 32'(readyA), 32'd0);
    check("ms_launched_we", 32'(weA),    32'd1);
    check("ms_launched_addr", 32'(addrA), 32'd0);
    tick();
    start = 1'b0;
    #1;
    check("ms_we_off", 32'(weA),    32'd0);
    check("ms_count",  32'(countA), 32'd0);
    check("ms_err",    32'(errA),   32'd0);
    check("ms_ready",  32'(readyA), 32'd1);
    tick(); noBeat();
    check("ms_addr",   32'(addrA),  32'd0);
    check("ms_data",   dataA,       32'h25123000);
    check("ms_count1", 32'(countA), 32'd1);

    // Reset mid-program.
    beat(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("mr_we",    32'(weA),    32'd0);
    check("mr_addr",  32'(addrA),  32'd0);
    check("mr_data",  dataA,       32'd0);
    check("mr_count", 32'(countA), 32'd0);
    check("mr_ready", 32'(readyA), 32'd0);
    reset = 1'b0;
    noBeat();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader / instruction encoder for the Lapido datapath, the encoding counterpart of the control unit's decoder. It accepts symbolic operations (op enum plus register and immediate fields) over a valid/ready handshake, packs each into the 32-bit instruction format the control unit decodes, and writes the words sequentially into instruction memory through a write port. The testbench or boot logic uses it to build programs without hand-assembling words.

## Interface
- ADDR_W, 8, instruction-memory address width; the program space holds 2^ADDR_W words.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: clear address, count and error, then enter RUN.
- in_valid  in  1  operation beat valid.
- in_ready  out  1  encoder accepts the beat; a transfer occurs when in_valid and in_ready are both high.
- in_op  in  6  operation enum from lapido_pkg.
- in_rd, in_ra, in_rb  in  4 each  register fields.
- in_imm  in  16  immediate for memory, constant and branch operations.
- in_last  in  1  final beat of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction word.
- count  out  ADDR_W+1  words written since start.
- done  out  1  program complete; held until start or reset.
- err  out  1  sticky error: illegal op or address wrap.

## Operation
- Word format:
  - [31:29] class: ALU 001, memory 100, constant 010, NOP 000, control transfer 101.
  - [28:24] function.
  - [23:20] rd, [19:16] ra, [15:12] rb.
  - [15:0] imm for memory, constant and branch words. It overrides rb; those operations do not encode rb.
- ALU functions: add 00000, addinc 00001, inca 00011, subdec 00100, sub 00101, deca 00110, lsl 01000, asr 01001, and 10000–11111 (zeros, and, andnota, passb, andnotb, passa, xor, or, nand, xnor, passnota, ornota, passnotb, ornotb, nor, ones, in that order).
- Other functions: load 00000, store 00001 (bit 24 = 1), loadlit 00010 (bits [25:24] = 10), nop 00000 with all other bits 0, beq 00100, bne 01000.
- States: IDLE, RUN, PAD, DONE.
  - IDLE: in_ready = 0. start → RUN.
  - RUN: in_ready = 1, except in the cycle start is high.
    - An accepted legal beat writes its word at imem_addr, then imem_addr increments and count increments.
    - An accepted beat with in_last: after its write (and pad, if any), go to DONE.
  - DONE: done = 1, in_ready = 0. start → RUN.
- Illegal op enum: the beat is consumed, nothing is written, err is set.
  - An illegal op with in_last still goes to DONE.
- Address wrap: a write at address 2^ADDR_W−1 sets err, and the next address is 0.
- start in any state clears imem_addr, count, err, done and any pending pad, then goes to RUN.
- start has priority over a simultaneous in_valid. The beat presented in that cycle is not accepted.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, done 0, err 0.
- A beat accepted in cycle N produces imem_we = 1 with address and data in cycle N+1. imem_we is 0 in every cycle without a write.
- Sustained throughput: one word per cycle.
- done rises in the cycle after the final write.
- err rises in the cycle after the offending beat or write.
- A write already launched from a beat in cycle N−1 completes in cycle N, even if start is asserted in cycle N.
- reset mid-program: everything returns to reset values on the next edge. Already-written memory is untouched.

## Configuration
- INSTR_ENCODER_BRANCH_PAD_EN
- Defined:
  - After a beq or bne is written, the encoder enters PAD for one cycle and writes a NOP (0x00000000) at the next address.
  - in_ready = 0 while the NOP is pending.
  - count includes the NOP. Wrap rules apply to the NOP write.
- Undefined: the PAD state is absent and branches are written back-to-back like any other word.

## Structure
- lapido_pkg holds the shared definitions:
  - op enum (30 values, 6-bit);
  - class constants;
  - function constants (the same 5-bit codes the control unit's ALUOp uses);
  - field bit positions.
- One sub-module, instr_pack: purely combinational op+fields → {legal, word[31:0]}.
- The FSM, address counter and output register live in instr_encoder.

## Test plan
- reset, start, add rd=1 ra=2 rb=3 → imem_we at 0 next cycle; addr 0 data 0x20123000; count 1.
- Back-to-back sub, loadlit imm=0x00AB, store rd=4 ra=5 imm=0x0010 with in_last on store:
  - data 0x25000000|fields, 0x420000AB|rd/ra, 0x81450010 at addrs 0,1,2;
  - done high the following cycle.
- Illegal enum (value 63) between two legal beats → no write for it; err = 1; addresses contiguous 0, 1.
- ADDR_W=2, five beats → writes at 3 then 0; err set at the wrap.
- beq imm=0x0004 with INSTR_ENCODER_BRANCH_PAD_EN → 0xA4000004 then 0x00000000; in_ready low for one cycle.
  - Without the macro: no NOP, in_ready stays high.
- start asserted mid-stream with in_valid high → that beat not accepted; next write at addr 0; count and err cleared.
